// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: gathers row-major pixels into 2x2 windows for an external
// pooling unit and returns each pooled result on a valid/ready output.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - frame start, honoured only in IDLE
//   in_valid/in_ready   - input pixel handshake, in_pixel (signed)
//   win, pool_en        - registered 2x2 window ([r][c]) and its enable pulse
//   pooled_pixel        - pooling result, qualified by pool_done
//   out_valid/out_ready - output handshake, out_pixel
//   frame_done          - one-cycle pulse after the last window is captured
//   err                 - sticky pooling-timeout flag
// Optional feature: define MAXPOOL_CTRL_TIMEOUT_EN to give up on pool_done
// after 16 waiting cycles (result forced to 0, err set).
module maxpool_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_pixel,
    output logic [1:0][1:0][DATA_WIDTH-1:0]  win,
    output logic                             pool_en,
    input  logic [DATA_WIDTH-1:0]            pooled_pixel,
    input  logic                             pool_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_pixel,
    output logic                             frame_done,
    output logic                             err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_POOL, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   col_q, col_d;
    logic [RW-1:0]                   row_q, row_d;
    logic [DATA_WIDTH-1:0]           held_q, held_d;
    logic [1:0][1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic                            pool_en_q, pool_en_d;
    logic                            last_q, last_d;
    logic                            out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]           out_pixel_q, out_pixel_d;
    logic [DATA_WIDTH-1:0]           lbuf_q [IMG_W];

    logic                            accept;
    logic                            lb_we;
    logic                            capture;
    logic [DATA_WIDTH-1:0]           cap_pixel;

`ifdef MAXPOOL_CTRL_TIMEOUT_EN
    logic [3:0]                      tmo_q, tmo_d;
    logic                            err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        held_d      = held_q;
        win_d       = win_q;
        pool_en_d   = 1'b0;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        capture     = 1'b0;
        cap_pixel   = pooled_pixel;
`ifdef MAXPOOL_CTRL_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif

        // Only take a pixel when the output slot is free or draining,
        // so a window result can never overwrite an unread one.
        in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        lb_we    = accept && !row_q[0];

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (row_q[0]) begin
                        if (!col_q[0]) begin
                            held_d = in_pixel;
                        end else begin
                            win_d[0][0] = lbuf_q[col_q - CW'(1)];
                            win_d[0][1] = lbuf_q[col_q];
                            win_d[1][0] = held_q;
                            win_d[1][1] = in_pixel;
                            pool_en_d   = 1'b1;
                            last_d      = (row_q == ROW_LAST) &&
                                          (col_q == COL_LAST);
                            state_d     = WAIT_POOL;
`ifdef MAXPOOL_CTRL_TIMEOUT_EN
                            tmo_d       = '0;
`endif
                        end
                    end
                end
            end
            WAIT_POOL: begin
                if (pool_done) begin
                    capture = 1'b1;
                end
`ifdef MAXPOOL_CTRL_TIMEOUT_EN
                else if (tmo_q == 4'd15) begin
                    capture   = 1'b1;
                    cap_pixel = '0;
                    err_d     = 1'b1;
                end
                tmo_d = tmo_q + 4'd1;
`endif
                if (capture) begin
                    state_d = last_q ? DONE : RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            out_valid_d = 1'b1;
            out_pixel_d = cap_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            held_q      <= '0;
            win_q       <= '0;
            pool_en_q   <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            held_q      <= held_d;
            win_q       <= win_d;
            pool_en_q   <= pool_en_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
        end
    end

    // Line buffer holds the even row; it is fully rewritten every
    // frame before being read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf_q[col_q] <= in_pixel;
        end
    end

`ifdef MAXPOOL_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign win        = win_q;
    assign pool_en    = pool_en_q;
    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign frame_done = (state_q == DONE);

endmodule
